// File: rtl/cpu_sequencer.sv
// Run-state / phase sequencer for a four-phase CPU datapath.
// Define SEQ_BREAKPOINT_EN to compile in the PC breakpoint logic.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_HALT | idle at FETCH; waiting for run or step
// ST_RUN  | free-running; stops at FETCH when run drops or on a breakpoint
// ST_STEP | executes exactly one instruction, then returns to ST_HALT
module cpu_sequencer #(
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               tick,
    input  logic               run,
    input  logic               step,
    input  logic [1:0]         opcode,
    input  logic [7:0]         pc,
    input  logic [7:0]         bp_addr,
    input  logic               bp_valid,
    output logic [1:0]         phase,
    output logic               pc_we,
    output logic               rf_we,
    output logic               dmem_re,
    output logic               dmem_we,
    output logic               halted,
    output logic               bp_hit,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } run_state_e;

    localparam logic [1:0] PH_FETCH = 2'd0;
    localparam logic [1:0] PH_EXEC  = 2'd1;
    localparam logic [1:0] PH_MEM   = 2'd2;
    localparam logic [1:0] PH_WB    = 2'd3;

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    run_state_e         state_q, state_d;
    logic [1:0]         phase_q, phase_d;
    logic [1:0]         op_q, op_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               bp_hit_q, bp_hit_d;
    logic               skip_q, skip_d;
    logic               bp_match;
    logic               stop_at_fetch;

`ifdef SEQ_BREAKPOINT_EN
    // skip_q suppresses the compare on the first FETCH after resuming from a break
    assign bp_match = (state_q == ST_RUN) && !skip_q && bp_valid && (pc == bp_addr);
    assign bp_hit   = bp_hit_q;
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr, bp_valid};
    assign bp_match  = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    assign stop_at_fetch = bp_match || ((state_q == ST_RUN) && !run);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        op_d     = op_q;
        count_d  = count_q;
        bp_hit_d = bp_hit_q;
        skip_d   = skip_q;
        pc_we    = 1'b0;
        rf_we    = 1'b0;
        dmem_we  = 1'b0;
        dmem_re  = (state_q != ST_HALT) && (phase_q == PH_MEM) && (op_q == OP_LOAD);

        case (state_q)
            ST_HALT: begin
                if (run || step) begin
                    state_d  = run ? ST_RUN : ST_STEP;
                    bp_hit_d = 1'b0;
                    skip_d   = bp_hit_q;
                end
            end
            ST_RUN, ST_STEP: begin
                if (tick) begin
                    skip_d = 1'b0;
                    if ((phase_q == PH_FETCH) && stop_at_fetch) begin
                        state_d = ST_HALT;
                        if (bp_match) begin
                            bp_hit_d = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + 2'd1;
                        case (phase_q)
                            PH_FETCH: op_d = opcode;
                            PH_EXEC:  ;
                            PH_MEM:   dmem_we = (op_q == OP_STORE);
                            PH_WB: begin
                                pc_we   = 1'b1;
                                rf_we   = !op_q[1];
                                count_d = count_q + COUNT_W'(1);
                                if ((state_q == ST_STEP) || !run) begin
                                    state_d = ST_HALT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = ST_HALT;
        endcase

        // clear kills the in-flight instruction before any strobe escapes
        if (clear) begin
            pc_we   = 1'b0;
            rf_we   = 1'b0;
            dmem_we = 1'b0;
            dmem_re = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= ST_HALT;
            phase_q  <= PH_FETCH;
            op_q     <= 2'b00;
            count_q  <= '0;
            bp_hit_q <= 1'b0;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            op_q     <= op_d;
            count_q  <= count_d;
            bp_hit_q <= bp_hit_d;
            skip_q   <= skip_d;
        end
    end

    assign phase       = phase_q;
    assign halted      = (state_q == ST_HALT);
    assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized and directed bench for cpu_sequencer against an instruction-level model.
module tb_cpu_sequencer;
    localparam int CW = 4;
`ifdef SEQ_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          clear, tick, run, step, bp_valid;
    logic [1:0]    opcode, phase;
    logic [7:0]    pc, bp_addr;
    logic          pc_we, rf_we, dmem_re, dmem_we, halted, bp_hit;
    logic [CW-1:0] instr_count;

    cpu_sequencer #(.COUNT_W(CW)) dut (
        .clock(clock), .clear(clear), .tick(tick), .run(run), .step(step),
        .opcode(opcode), .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
        .phase(phase), .pc_we(pc_we), .rf_we(rf_we), .dmem_re(dmem_re),
        .dmem_we(dmem_we), .halted(halted), .bp_hit(bp_hit), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // model: mode 0 halted, 1 running, 2 single step
    int m_mode, m_ph, m_op, m_cnt;
    bit m_bph, m_skip;
    int n_pc, n_rf, n_dwe;
    bit last_dwe;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_ph = 0; m_op = 0; m_cnt = 0; m_bph = 0; m_skip = 0;
    endtask

    task automatic cycle(input bit clr, input bit tk, input bit rn, input bit st,
                         input logic [1:0] op, input logic [7:0] p);
        bit act, brk;
        clear = clr; tick = tk; run = rn; step = st; opcode = op; pc = p;
        @(negedge clock);
        act = !clr && tk && (m_mode != 0);
        check_eq("phase",   int'(phase),       m_ph);
        check_eq("halted",  int'(halted),      int'(m_mode == 0));
        check_eq("count",   int'(instr_count), m_cnt);
        check_eq("bp_hit",  int'(bp_hit),      int'(m_bph));
        check_eq("pc_we",   int'(pc_we),       int'(act && m_ph == 3));
        check_eq("rf_we",   int'(rf_we),       int'(act && m_ph == 3 && m_op <= 1));
        check_eq("dmem_we", int'(dmem_we),     int'(act && m_ph == 2 && m_op == 2));
        check_eq("dmem_re", int'(dmem_re),     int'(!clr && m_mode != 0 && m_ph == 2 && m_op == 1));
        n_pc  += int'(pc_we);
        n_rf  += int'(rf_we);
        n_dwe += int'(dmem_we);
        last_dwe = dmem_we;
        @(posedge clock);
        #1;
        if (clr) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (rn || st) begin
                m_mode = rn ? 1 : 2;
                m_skip = m_bph;
                m_bph  = 0;
            end
        end else if (tk) begin
            brk = BP_EN && m_mode == 1 && m_ph == 0 && !m_skip && bp_valid && p == bp_addr;
            m_skip = 0;
            if (m_ph == 0 && (brk || (m_mode == 1 && !rn))) begin
                m_mode = 0;
                if (brk) m_bph = 1;
            end else begin
                if (m_ph == 0) m_op = int'(op);
                if (m_ph == 3) begin
                    m_cnt = (m_cnt + 1) % (1 << CW);
                    if (m_mode == 2 || !rn) m_mode = 0;
                end
                m_ph = (m_ph + 1) % 4;
            end
        end
    endtask

    task automatic clear_counts();
        n_pc = 0; n_rf = 0; n_dwe = 0;
    endtask

    int  dwe_at[$];
    bit  r_run;
    logic [1:0] r_op;

    initial begin
        clear = 1; tick = 0; run = 0; step = 0; opcode = 0; pc = 0;
        bp_addr = 8'h05; bp_valid = 0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        clear_counts();

        // reset state
        check_eq("rst_halted", int'(halted), 1);
        check_eq("rst_phase",  int'(phase), 0);
        check_eq("rst_count",  int'(instr_count), 0);
        check_eq("rst_bp_hit", int'(bp_hit), 0);

        // single step of an ALU op
        cycle(1, 0, 0, 0, 2'b00, 8'h00);
        cycle(0, 0, 0, 1, 2'b00, 8'h00);
        clear_counts();
        for (int k = 1; k <= 4; k++) begin
            cycle(0, 1, 0, 0, 2'b00, 8'h00);
            check_eq("step_phase", int'(phase), k % 4);
        end
        check_eq("step_rf_n",  n_rf, 1);
        check_eq("step_pc_n",  n_pc, 1);
        check_eq("step_count", int'(instr_count), 1);
        check_eq("step_halt",  int'(halted), 1);

        // free-running stores
        cycle(1, 0, 0, 0, 2'b10, 8'h00);
        cycle(0, 0, 1, 0, 2'b10, 8'h00);
        clear_counts();
        for (int k = 1; k <= 8; k++) begin
            cycle(0, 1, 1, 0, 2'b10, 8'h00);
            if (last_dwe) dwe_at.push_back(k);
        end
        check_eq("st_dwe_n",  dwe_at.size(), 2);
        if (dwe_at.size() == 2) begin
            check_eq("st_dwe_t0", dwe_at[0], 3);
            check_eq("st_dwe_t1", dwe_at[1], 7);
        end
        check_eq("st_rf_n",   n_rf, 0);
        check_eq("st_count",  int'(instr_count), 2);

        // run dropped mid-instruction still completes it
        cycle(1, 0, 0, 0, 2'b01, 8'h00);
        cycle(0, 0, 1, 0, 2'b01, 8'h00);
        clear_counts();
        cycle(0, 1, 1, 0, 2'b01, 8'h00);
        cycle(0, 1, 1, 0, 2'b01, 8'h00);
        cycle(0, 1, 0, 0, 2'b01, 8'h00);
        cycle(0, 1, 0, 0, 2'b01, 8'h00);
        check_eq("drop_pc_n",  n_pc, 1);
        check_eq("drop_halt",  int'(halted), 1);
        check_eq("drop_phase", int'(phase), 0);

        // breakpoint hit, then resume past it
        cycle(1, 0, 0, 0, 2'b00, 8'h05);
        bp_valid = 1;
        cycle(0, 0, 1, 0, 2'b00, 8'h05);
        clear_counts();
        cycle(0, 1, 1, 0, 2'b00, 8'h05);
        check_eq("bp_halt", int'(halted), int'(BP_EN));
        check_eq("bp_flag", int'(bp_hit), int'(BP_EN));
        check_eq("bp_nostrobe", n_pc + n_rf + n_dwe, 0);
        cycle(0, 0, 1, 0, 2'b00, 8'h05);
        check_eq("bp_resume_flag", int'(bp_hit), 0);
        clear_counts();
        for (int k = 0; k < 4; k++) cycle(0, 1, 1, 0, 2'b00, 8'h05);
        check_eq("bp_resume_pc_n", n_pc, 1);
        bp_valid = 0;

        // counter wrap at CW=4
        cycle(1, 0, 0, 0, 2'b11, 8'h00);
        cycle(0, 0, 1, 0, 2'b11, 8'h00);
        for (int k = 0; k < 60; k++) cycle(0, 1, 1, 0, 2'b11, 8'h00);
        check_eq("wrap_15", int'(instr_count), 15);
        for (int k = 0; k < 4; k++) cycle(0, 1, 1, 0, 2'b11, 8'h00);
        check_eq("wrap_0", int'(instr_count), 0);

        // clear with tick during MEM of a store
        cycle(1, 0, 0, 0, 2'b10, 8'h00);
        cycle(0, 0, 1, 0, 2'b10, 8'h00);
        cycle(0, 1, 1, 0, 2'b10, 8'h00);
        cycle(0, 1, 1, 0, 2'b10, 8'h00);
        check_eq("clr_in_mem", int'(phase), 2);
        clear_counts();
        cycle(1, 1, 1, 0, 2'b10, 8'h00);
        check_eq("clr_dwe_n", n_dwe, 0);
        check_eq("clr_phase", int'(phase), 0);
        check_eq("clr_halt",  int'(halted), 1);
        check_eq("clr_count", int'(instr_count), 0);

        // randomized traffic
        r_run = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) r_run = !r_run;
            if ($urandom_range(0, 29) == 0) bp_valid = !bp_valid;
            r_op = 2'($urandom_range(0, 3));
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, r_run,
                  $urandom_range(0, 7) == 0, r_op,
                  ($urandom_range(0, 2) == 0) ? 8'h05 : 8'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
